// File: rtl/huff_bit_packer.sv
// rtl/huff_bit_packer.sv - packs Huffman codes for an 8-bit character stream into MSB-first OUT_W-bit words
module huff_bit_packer #(
    parameter int NUM_SYM = 3,
    parameter int CODE_W  = 3,
    parameter int OUT_W   = 8,
    localparam int IDX_W  = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1,
    localparam int NB_W   = $clog2(OUT_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tbl_wr,
    input  logic [IDX_W-1:0]  tbl_idx,
    input  logic [7:0]        tbl_char,
    input  logic [CODE_W-1:0] tbl_mask,
    input  logic [CODE_W-1:0] tbl_value,
    input  logic              start,
    input  logic              sym_valid,
    output logic              sym_ready,
    input  logic [7:0]        sym_char,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [NB_W-1:0]   out_nbits,
    output logic              flush_done,
    output logic              err
);
    localparam int ACC_W  = OUT_W + CODE_W - 1;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int LEN_W  = $clog2(CODE_W + 1);
    localparam logic [FILL_W-1:0] FILL_OUT  = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] FILL_ACC  = FILL_W'(ACC_W);
    localparam logic [IDX_W:0]    NUM_SYM_W = (IDX_W + 1)'(NUM_SYM);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t             state;
    logic [7:0]         tbl_char_q  [NUM_SYM];
    logic [CODE_W-1:0]  tbl_mask_q  [NUM_SYM];
    logic [CODE_W-1:0]  tbl_value_q [NUM_SYM];
    logic [ACC_W-1:0]   acc;
    logic [FILL_W-1:0]  fill;

    logic               hit;
    logic [CODE_W-1:0]  hit_mask;
    logic [CODE_W-1:0]  hit_value;
    logic [LEN_W-1:0]   hit_len;
    logic [ACC_W-1:0]   hit_code;
    logic [FILL_W-1:0]  shamt;
    logic               sym_fire;
    logic               reg_free;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit       = 1'b0;
        hit_mask  = '0;
        hit_value = '0;
        for (int i = NUM_SYM - 1; i >= 0; i--) begin
            if (tbl_char_q[i] == sym_char) begin
                hit       = 1'b1;
                hit_mask  = tbl_mask_q[i];
                hit_value = tbl_value_q[i];
            end
        end
        hit_len = '0;
        for (int b = 0; b < CODE_W; b++) begin
            hit_len = hit_len + LEN_W'(hit_mask[b]);
        end
        hit_code = ACC_W'(hit_value & hit_mask);
        shamt    = FILL_ACC - fill - FILL_W'(hit_len);
    end

    assign sym_ready = (state == RUN) && (fill < FILL_OUT);
    assign sym_fire  = sym_valid && sym_ready;
    assign reg_free  = !out_valid || out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            acc        <= '0;
            fill       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_nbits  <= '0;
            flush_done <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < NUM_SYM; i++) begin
                tbl_char_q[i]  <= '0;
                tbl_mask_q[i]  <= '0;
                tbl_value_q[i] <= '0;
            end
        end else begin
            flush_done <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (tbl_wr && ({1'b0, tbl_idx} < NUM_SYM_W)) begin
                        tbl_char_q[tbl_idx]  <= tbl_char;
                        tbl_mask_q[tbl_idx]  <= tbl_mask;
                        tbl_value_q[tbl_idx] <= tbl_value;
                    end
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (fill >= FILL_OUT) begin
                        if (reg_free) begin
                            out_data  <= acc[ACC_W-1 -: OUT_W];
                            out_nbits <= NB_W'(OUT_W);
                            out_valid <= 1'b1;
                            acc       <= acc << OUT_W;
                            fill      <= fill - FILL_OUT;
                        end
                    end else if (sym_fire) begin
                        if (hit && (hit_len != '0)) begin
                            acc  <= acc | (hit_code << shamt);
                            fill <= fill + FILL_W'(hit_len);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    if (flush) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Bits below fill are always zero, so the padded word needs no masking.
                    if (fill >= FILL_OUT) begin
                        if (reg_free) begin
                            out_data  <= acc[ACC_W-1 -: OUT_W];
                            out_nbits <= NB_W'(OUT_W);
                            out_valid <= 1'b1;
                            acc       <= acc << OUT_W;
                            fill      <= fill - FILL_OUT;
                        end
                    end else if (fill != '0) begin
                        if (reg_free) begin
                            out_data  <= acc[ACC_W-1 -: OUT_W];
                            out_nbits <= NB_W'(fill);
                            out_valid <= 1'b1;
                            acc       <= '0;
                            fill      <= '0;
                        end
                    end else if (!out_valid) begin
                        flush_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_huff_bit_packer.sv
// tb/tb_huff_bit_packer.sv - directed self-checking bench for huff_bit_packer
module tb_huff_bit_packer;
    logic       clk = 1'b0;
    logic       reset;
    logic       tbl_wr;
    logic [1:0] tbl_idx;
    logic [7:0] tbl_char;
    logic [2:0] tbl_mask;
    logic [2:0] tbl_value;
    logic       start;
    logic       sym_valid;
    logic       sym_ready;
    logic [7:0] sym_char;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_nbits;
    logic       flush_done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [11:0] words[$];

    huff_bit_packer #(.NUM_SYM(3), .CODE_W(3), .OUT_W(8)) dut (
        .clk(clk), .reset(reset), .tbl_wr(tbl_wr), .tbl_idx(tbl_idx),
        .tbl_char(tbl_char), .tbl_mask(tbl_mask), .tbl_value(tbl_value),
        .start(start), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_char(sym_char), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_nbits(out_nbits),
        .flush_done(flush_done), .err(err)
    );

    always #5 clk = ~clk;

    // Records every handshaken word just before the rising edge that consumes it.
    always @(negedge clk) begin
        #4;
        if (reset && out_valid && out_ready) words.push_back({out_nbits, out_data});
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic load_entry(input logic [1:0] idx, input logic [7:0] ch,
                              input logic [2:0] m, input logic [2:0] v);
        tbl_wr = 1'b1; tbl_idx = idx; tbl_char = ch; tbl_mask = m; tbl_value = v;
        @(negedge clk);
        tbl_wr = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_sym(input logic [7:0] ch);
        int n = 0;
        sym_valid = 1'b1; sym_char = ch;
        while (!sym_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 50) begin
            n_fail++;
            $display("FAIL send_sym_timeout: char %h never accepted, sym_ready=%b required 1", ch, sym_ready);
        end
        @(negedge clk);
        sym_valid = 1'b0;
    endtask

    task automatic do_flush(output int wait_cycles, output logic seen);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        seen = 1'b0;
        wait_cycles = 0;
        while (!seen && wait_cycles < 40) begin
            if (flush_done) seen = 1'b1;
            else begin
                @(negedge clk);
                wait_cycles++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; tbl_wr = 0; tbl_idx = 0; tbl_char = 0; tbl_mask = 0; tbl_value = 0;
        start = 0; sym_valid = 0; sym_char = 0; flush = 0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out_valid, out_data, out_nbits, sym_ready, flush_done, err} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h nb=%0d rdy=%b fd=%b err=%b required all 0",
                     out_valid, out_data, out_nbits, sym_ready, flush_done, err);
        end
        reset = 1'b1;
        @(negedge clk);
        load_entry(2'd0, "a", 3'b011, 3'b000);
        load_entry(2'd1, "b", 3'b011, 3'b001);
        load_entry(2'd2, "c", 3'b001, 3'b001);
        load_entry(2'd3, "a", 3'b001, 3'b001);
    endtask

    task automatic test_full_word();
        int wc; logic seen;
        words.delete();
        do_start();
        send_sym("a"); send_sym("b"); send_sym("c"); send_sym("c"); send_sym("a");
        repeat (4) @(negedge clk);
        n_checks++;
        if (words.size() != 1 || words[0] !== {4'd8, 8'h1C}) begin
            n_fail++;
            $display("FAIL full_word: got %0d words first=%h required 1 word 81c", words.size(),
                     words.size() > 0 ? words[0] : 12'h0);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL full_word_err: got %b required 0", err);
        end
        do_flush(wc, seen);
        n_checks++;
        if (!seen || wc > 2) begin
            n_fail++;
            $display("FAIL empty_flush_done: seen=%b after %0d cycles required within 2", seen, wc);
        end
        @(negedge clk);
        n_checks++;
        if (flush_done !== 1'b0 || words.size() != 1) begin
            n_fail++;
            $display("FAIL empty_flush_pulse: flush_done=%b words=%0d required 0 and 1", flush_done, words.size());
        end
    endtask

    task automatic test_partial();
        int wc; logic seen;
        words.delete();
        do_start();
        send_sym("a"); send_sym("c");
        do_flush(wc, seen);
        n_checks++;
        if (!seen || words.size() != 1 || words[0] !== {4'd3, 8'h20}) begin
            n_fail++;
            $display("FAIL partial_word: seen=%b words=%0d first=%h required 1 word 320", seen,
                     words.size(), words.size() > 0 ? words[0] : 12'h0);
        end
        @(negedge clk);
        n_checks++;
        if (sym_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_idle: sym_ready=%b required 0", sym_ready);
        end
    endtask

    task automatic test_backpressure();
        int wc; logic seen;
        words.delete();
        out_ready = 1'b0;
        do_start();
        repeat (4) send_sym("a");
        repeat (4) send_sym("b");
        repeat (3) @(negedge clk);
        n_checks++;
        if (sym_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h00 || out_nbits !== 4'd8) begin
            n_fail++;
            $display("FAIL backpressure_hold: rdy=%b v=%b d=%h nb=%0d required 0 1 00 8",
                     sym_ready, out_valid, out_data, out_nbits);
        end
        out_ready = 1'b1;
        repeat (8) send_sym("c");
        do_flush(wc, seen);
        n_checks++;
        if (!seen || words.size() != 3) begin
            n_fail++;
            $display("FAIL backpressure_count: seen=%b words=%0d required 3", seen, words.size());
        end else begin
            n_checks++;
            if (words[0] !== 12'h800 || words[1] !== 12'h855 || words[2] !== 12'h8FF) begin
                n_fail++;
                $display("FAIL backpressure_order: got %h %h %h required 800 855 8ff",
                         words[0], words[1], words[2]);
            end
        end
    endtask

    task automatic test_unknown_char();
        int wc; logic seen;
        words.delete();
        do_start();
        send_sym("a"); send_sym("z"); send_sym("c");
        do_flush(wc, seen);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL unknown_err: got %b required 1", err);
        end
        n_checks++;
        if (!seen || words.size() != 1 || words[0] !== {4'd3, 8'h20}) begin
            n_fail++;
            $display("FAIL unknown_bits: words=%0d first=%h required 1 word 320", words.size(),
                     words.size() > 0 ? words[0] : 12'h0);
        end
    endtask

    task automatic test_flush_with_sym();
        int wc; logic seen;
        words.delete();
        do_start();
        send_sym("a"); send_sym("b"); send_sym("c"); send_sym("a");
        n_checks++;
        if (sym_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_sym_ready: sym_ready=%b required 1 at fill 7", sym_ready);
        end
        sym_valid = 1'b1; sym_char = "c";
        do_flush(wc, seen);
        sym_valid = 1'b0;
        n_checks++;
        if (!seen || words.size() != 1 || words[0] !== {4'd8, 8'h19}) begin
            n_fail++;
            $display("FAIL flush_with_sym: seen=%b words=%0d first=%h required 1 word 819", seen,
                     words.size(), words.size() > 0 ? words[0] : 12'h0);
        end
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b required 1", err);
        end
    endtask

    task automatic test_reset_mid();
        int wc; logic seen;
        words.delete();
        out_ready = 1'b0;
        do_start();
        repeat (4) send_sym("a");
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: out_valid=%b required 1", out_valid);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || err !== 1'b0 || sym_ready !== 1'b0 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: v=%b err=%b rdy=%b d=%h required 0 0 0 00",
                     out_valid, err, sym_ready, out_data);
        end
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        do_start();
        send_sym("a");
        do_flush(wc, seen);
        n_checks++;
        if (err !== 1'b1 || !seen || words.size() != 0) begin
            n_fail++;
            $display("FAIL table_cleared: err=%b seen=%b words=%0d required 1 1 0", err, seen, words.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_word();
        test_partial();
        test_backpressure();
        test_unknown_char();
        test_flush_with_sym();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/huff_bit_packer.md
Name: huff_bit_packer

Overview:
- Sits directly downstream of the Huffman encoder. Consumes the per-character code table it produces: char, encoded_mask and encoded_value, NUM_SYM entries.
- Then converts a stream of raw 8-bit characters into a packed, MSB-first bitstream of fixed OUT_W-bit words with valid/ready handshakes on both sides.
- A flush command zero-pads and emits the trailing partial word.

Parameters:
- NUM_SYM, 3, code-table entries (matches encoder character count)
- CODE_W, 3, max code length in bits; width of tbl_mask/tbl_value
- OUT_W, 8, output word width

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- tbl_wr  in  1  table write strobe
- tbl_idx  in  $clog2(NUM_SYM)  table entry index
- tbl_char  in  8  character for entry
- tbl_mask  in  CODE_W  encoder mask, (1<<len)-1
- tbl_value  in  CODE_W  code bits, bit len-1 = first (root) bit
- start  in  1  pulse: IDLE->RUN
- sym_valid  in  1  character available
- sym_ready  out  1  character accepted when valid&ready
- sym_char  in  8  character to encode
- flush  in  1  pulse: drain and pad remaining bits
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts word
- out_data  out  OUT_W  packed bits, first bit at MSB
- out_nbits  out  $clog2(OUT_W+1)  valid bits in out_data (MSB-aligned)
- flush_done  out  1  one-cycle pulse, flush complete
- err  out  1  sticky: unknown char or zero-length code seen

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All table masks/values/chars=0.
  - Accumulator and fill=0.
  - out_valid=0, out_data=0, out_nbits=0, sym_ready=0, flush_done=0, err=0.
- Storage:
  - Accumulator of OUT_W+CODE_W-1 bits, fill counter 0..OUT_W+CODE_W-1.
  - Single output register (out_data/out_nbits/out_valid).
- States:
  - IDLE: tbl_wr writes entry tbl_idx (idx>=NUM_SYM ignored). start -> RUN. sym_ready=0. flush ignored.
  - RUN: tbl_wr ignored. sym_ready = (fill < OUT_W). flush -> FLUSH.
  - FLUSH: sym_ready=0. Drain. On completion pulse flush_done for 1 cycle, then -> IDLE. The table is retained, so a new start needs no reload.
- Symbol accept (RUN, sym_valid&sym_ready):
  - Look up sym_char against all NUM_SYM tbl_char entries; the lowest matching index wins.
  - len = popcount(mask). Append value[len-1:0] after the existing bits (bit len-1 first); fill += len.
  - No match, or len==0: symbol consumed, no bits added, err<=1 (cleared only by reset).
- Word emit: any cycle with fill>=OUT_W and (!out_valid | out_ready):
  - out_data <= oldest OUT_W bits, out_nbits <= OUT_W, out_valid <= 1.
  - Remaining bits shift up; fill -= OUT_W.
  - Emit and accept never coincide, because accept needs fill<OUT_W.
- Output register:
  - Word held stable while out_valid & !out_ready.
  - out_valid drops the cycle after handshake unless a new word loads.
- flush and sym accept in the same cycle: the symbol is appended first, then FLUSH is entered.
- FLUSH draining:
  - Full words emit as above.
  - When 0<fill<OUT_W and the output register is free, emit a padded word: remaining bits MSB-aligned, zeros below, out_nbits=fill. fill <= 0.
  - Completion: fill==0 and out_valid==0 (last word handshaken). If fill==0 on entry with nothing pending, flush_done pulses the cycle after flush.
- Latency:
  - Accepted symbol bits are in the accumulator next cycle.
  - A word becomes out_valid one cycle after fill reaches >=OUT_W, if the register is free.
- Reset mid-operation: everything returns to reset values immediately; a partial word is discarded.

Test Plan:
- Load 'a'(mask 011,val 00), 'b'(011,01), 'c'(001,1), start. Send a,b,c,c,a -> one word out_data=0x1C, out_nbits=8. Then flush -> no word, flush_done pulses next cycle.
- Same table, send a,c, flush -> out_data=0x20, out_nbits=3, then flush_done, state IDLE.
- Hold out_ready=0, stream 'a' continuously -> word0=0x00 held stable. sym_ready drops once fill>=8 with the register full. Raise out_ready -> words drain in order, no bits lost.
- Send 'z' (not in table) between 'a' and 'c' -> err=1 sticky, word bits identical to the stream without 'z'.
- sym_valid('c') and flush in the same cycle with fill=7 -> 'c' appended, word 0x?? with nbits 8 emitted, then flush_done. No padded word.
- Assert reset during RUN with out_valid=1 -> out_valid, err, sym_ready=0 immediately. Table cleared: after start, 'a' sets err.
